// File: rtl/game_pkg.sv
// game_pkg: shared constants and writeback FSM states for the score keeper.
package game_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int WORD_W = 32;
  localparam logic [REG_ADDR_W-1:0] SCORE_REG = 5'd28;
  typedef enum logic {IDLE, REQ} wb_state_t;
endpackage

// File: rtl/streak_tracker.sv
// streak_tracker: hit streak, step counter and multiplier.
//   clock, resetn : clock, async active-low reset
//   hit, miss     : one-cycle qualified strum events
//   streak        : consecutive hits, saturates at 255
//   multiplier    : 1..MAX_MULT, bumps every STREAK_STEP consecutive hits
module streak_tracker #(
  parameter int STREAK_STEP = 10,
  parameter int MAX_MULT = 4
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       hit,
  input  logic       miss,
  output logic [7:0] streak,
  output logic [2:0] multiplier
);
  localparam int STEP_W = $clog2(STREAK_STEP + 1);
  logic [STEP_W-1:0] r_step;
  logic [7:0] r_streak;
  logic [2:0] r_mult;
  logic w_wrap;
  assign w_wrap = r_step == STEP_W'(STREAK_STEP - 1);
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_step <= '0;
      r_streak <= '0;
      r_mult <= 3'd1;
    end else if (miss) begin
      r_step <= '0;
      r_streak <= '0;
      r_mult <= 3'd1;
    end else if (hit) begin
      r_streak <= (r_streak == 8'hff) ? r_streak : r_streak + 8'd1;
      r_step <= w_wrap ? '0 : r_step + STEP_W'(1);
      r_mult <= (w_wrap && r_mult < 3'(MAX_MULT)) ? r_mult + 3'd1 : r_mult;
    end
  end
  assign streak = r_streak;
  assign multiplier = r_mult;
endmodule

// File: rtl/score_keeper.sv
// score_keeper: score accumulator with saturation and r28 writeback port.
//   clock, resetn      : clock, async active-low reset
//   update, inc        : strum event, inc=1 hit / inc=0 miss
//   wb_req/ack/addr/data : req/ack register write of the score snapshot
//   score, streak, multiplier, miss_pulse, sat_flag : game state
module score_keeper import game_pkg::*; #(
  parameter int SCORE_W = WORD_W,
  parameter int HIT_POINTS = 10,
  parameter int STREAK_STEP = 10,
  parameter int MAX_MULT = 4,
  parameter logic [REG_ADDR_W-1:0] SCORE_REG_P = SCORE_REG
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  update,
  input  logic                  inc,
  input  logic                  wb_ack,
  output logic                  wb_req,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic [SCORE_W-1:0]    wb_data,
  output logic [SCORE_W-1:0]    score,
  output logic [7:0]            streak,
  output logic [2:0]            multiplier,
  output logic                  miss_pulse,
  output logic                  sat_flag
);
  wb_state_t r_state, w_next;
  logic [SCORE_W-1:0] r_score, r_wb_data;
  logic r_sat, r_dirty, r_miss;
  logic w_hit, w_miss;
  logic [SCORE_W:0] w_sum;
  logic [7:0] w_streak;
  logic [2:0] w_mult;
  assign w_hit = update & inc;
  assign w_miss = update & ~inc;
  // extra carry bit detects overflow; multiplier is the pre-hit value
  assign w_sum = {1'b0, r_score} + (SCORE_W+1)'(HIT_POINTS) * (SCORE_W+1)'(w_mult);
  streak_tracker #(.STREAK_STEP(STREAK_STEP), .MAX_MULT(MAX_MULT)) u_streak (
    .clock(clock),
    .resetn(resetn),
    .hit(w_hit),
    .miss(w_miss),
    .streak(w_streak),
    .multiplier(w_mult)
  );
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE) ? (r_dirty ? REQ : IDLE) : (wb_ack ? IDLE : REQ);
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_score <= '0;
      r_sat <= 1'b0;
      r_dirty <= 1'b0;
      r_wb_data <= '0;
      r_miss <= 1'b0;
    end else begin
      r_miss <= w_miss;
      if (w_hit) begin
        r_score <= w_sum[SCORE_W] ? '1 : w_sum[SCORE_W-1:0];
        r_sat <= r_sat | w_sum[SCORE_W];
      end
      if (r_state == IDLE && r_dirty) r_wb_data <= r_score;
      // leaving IDLE consumes dirty; a same-cycle hit re-arms it
      r_dirty <= w_hit | (r_dirty & (r_state == REQ));
    end
  end
  assign wb_req = r_state == REQ;
  assign wb_addr = wb_req ? SCORE_REG_P : '0;
  assign wb_data = r_wb_data;
  assign score = r_score;
  assign streak = w_streak;
  assign multiplier = w_mult;
  assign miss_pulse = r_miss;
  assign sat_flag = r_sat;
endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: randomized and directed checks against an event-level model.
module tb_score_keeper;
  logic clock = 0, resetn = 0, update = 0, inc = 0, wb_ack = 0;
  logic wb_req, miss_pulse, sat_flag;
  logic [4:0] wb_addr;
  logic [31:0] wb_data, score;
  logic [7:0] streak;
  logic [2:0] multiplier;
  logic wb_req8, miss_pulse8, sat_flag8;
  logic [4:0] wb_addr8;
  logic [7:0] wb_data8, score8, streak8;
  logic [2:0] multiplier8;
  int n_tests = 0, n_fail = 0;
  longint m_score, m_score8, m_data, m_data8;
  int m_run;
  bit m_req, m_pend, m_sat, m_sat8, m_missp;
  score_keeper u_dut (
    .clock(clock), .resetn(resetn), .update(update), .inc(inc), .wb_ack(wb_ack),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data), .score(score),
    .streak(streak), .multiplier(multiplier), .miss_pulse(miss_pulse), .sat_flag(sat_flag)
  );
  score_keeper #(.SCORE_W(8)) u_dut8 (
    .clock(clock), .resetn(resetn), .update(update), .inc(inc), .wb_ack(wb_ack),
    .wb_req(wb_req8), .wb_addr(wb_addr8), .wb_data(wb_data8), .score(score8),
    .streak(streak8), .multiplier(multiplier8), .miss_pulse(miss_pulse8), .sat_flag(sat_flag8)
  );
  always #5 clock = ~clock;
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask
  function automatic int m_mult();
    return (1 + m_run / 10 > 4) ? 4 : 1 + m_run / 10;
  endfunction
  function automatic longint clamp(longint v, longint mx);
    return v > mx ? mx : v;
  endfunction
  task automatic model_reset();
    m_score = 0; m_score8 = 0; m_data = 0; m_data8 = 0; m_run = 0;
    m_req = 0; m_pend = 0; m_sat = 0; m_sat8 = 0; m_missp = 0;
  endtask
  task automatic model_edge(bit u, bit i, bit a);
    longint add;
    if (m_req) begin
      if (a) m_req = 0;
    end else if (m_pend) begin
      m_req = 1; m_pend = 0; m_data = m_score; m_data8 = m_score8;
    end
    m_missp = u & !i;
    if (u && i) begin
      add = 10 * m_mult();
      if (m_score + add > 64'hFFFF_FFFF) m_sat = 1;
      if (m_score8 + add > 255) m_sat8 = 1;
      m_score = clamp(m_score + add, 64'hFFFF_FFFF);
      m_score8 = clamp(m_score8 + add, 255);
      m_run++;
      m_pend = 1;
    end else if (u) m_run = 0;
  endtask
  task automatic compare();
    check("score", score, m_score);
    check("streak", streak, m_run > 255 ? 255 : m_run);
    check("mult", multiplier, m_mult());
    check("miss_pulse", miss_pulse, m_missp);
    check("sat", sat_flag, m_sat);
    check("wb_req", wb_req, m_req);
    check("wb_addr", wb_addr, m_req ? 28 : 0);
    check("wb_data", wb_data, m_data);
    check("score8", score8, m_score8);
    check("sat8", sat_flag8, m_sat8);
    check("wb_req8", wb_req8, m_req);
    check("wb_data8", wb_data8, m_data8);
  endtask
  task automatic cyc(bit u, bit i, bit a);
    update = u; inc = i; wb_ack = a;
    @(posedge clock);
    model_edge(u, i, a);
    @(negedge clock);
    compare();
    update = 0; inc = 0;
  endtask
  task automatic do_reset();
    resetn = 0;
    #1;
    check("rst_async_req", wb_req, 0);
    check("rst_async_req8", wb_req8, 0);
    check("rst_async_addr", wb_addr, 0);
    model_reset();
    @(negedge clock);
    compare();
    check("rst_mult", multiplier, 1);
    resetn = 1;
  endtask
  initial begin
    longint snap;
    model_reset();
    @(negedge clock);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      cyc(1, 1, 1);
      cyc(0, 0, 1);
      check("p1_req", wb_req, 1);
      check("p1_addr", wb_addr, 28);
      check("p1_data", wb_data, 10 * (k + 1));
      check("p1_mult", multiplier, 1);
      cyc(0, 0, 1);
    end
    do_reset();
    for (int k = 0; k < 10; k++) cyc(1, 1, 1);
    check("p2_score100", score, 100);
    check("p2_mult2", multiplier, 2);
    check("p2_streak10", streak, 10);
    cyc(1, 1, 1);
    check("p2_score120", score, 120);
    for (int k = 0; k < 9; k++) cyc(1, 1, 1);
    check("p3_mult3", multiplier, 3);
    for (int k = 0; k < 4; k++) cyc(0, 0, 1);
    snap = score;
    cyc(1, 0, 0);
    check("p3_miss", miss_pulse, 1);
    check("p3_streak0", streak, 0);
    check("p3_mult1", multiplier, 1);
    check("p3_score_hold", score, snap);
    cyc(0, 0, 0);
    check("p3_miss_off", miss_pulse, 0);
    check("p3_noreq", wb_req, 0);
    cyc(1, 1, 0);
    snap = score;
    for (int k = 1; k < 8; k++) cyc(k % 2 == 0, 1, 0);
    check("p4_frozen", wb_data, snap);
    cyc(0, 0, 1);
    check("p4_gap", wb_req, 0);
    cyc(0, 0, 0);
    check("p4_req2", wb_req, 1);
    check("p4_final", wb_data, score);
    cyc(0, 0, 1);
    do_reset();
    for (int k = 0; k < 45; k++) cyc(1, 1, $urandom_range(0, 1));
    check("p5_clamp", score8, 255);
    check("p5_sat", sat_flag8, 1);
    cyc(1, 0, 1);
    cyc(1, 1, 1);
    check("p5_sat_sticky", sat_flag8, 1);
    cyc(1, 1, 0);
    cyc(0, 0, 0);
    check("p6_inreq", wb_req, 1);
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      else cyc($urandom_range(0, 1), $urandom_range(0, 4) != 0, $urandom_range(0, 1));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
